// File: rtl/if_fetch_ctrl_pkg.sv
// Fetch-controller configuration macros, state encoding and PC legality helper.
// Shared by if_fetch_ctrl, if_fetch_queue and anything that drives them.
`ifndef IF_FETCH_CTRL_CFG
`define IF_FETCH_CTRL_CFG
`define XLEN 32
`define BOOT_IT_ADDR 32'h0000_1000
`define IT_RAM_DEPTH 32'h0000_0400
`define WRITE_ENABLE 1'b1
`define FETCH_Q_DEPTH 2
`endif

package if_fetch_ctrl_pkg;

  localparam int unsigned XW = `XLEN;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

  localparam logic [XW-1:0] PC_LIMIT =
    XW'(`BOOT_IT_ADDR + `IT_RAM_DEPTH);

  function automatic logic pc_legal(input logic [XW-1:0] a);
    return (a[1:0] == 2'b00) && (a < PC_LIMIT);
  endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Small synchronous FIFO holding {instruction, pc} entries for decode.
// Flush has priority over push and pop; head is combinational.
module if_fetch_queue
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_din,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  // The issue rule reserves a slot per request, so this never fires.
  always_ff @(posedge clk) begin
    if (rst_n && i_push && !i_pop && !i_flush)
      assert (r_cnt != FULL);
  end

  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC advance, IT RAM issue, decode queue.
// Optional IF_FETCH_PERF_EN adds handshake and stall counters.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int QDEPTH  = `FETCH_Q_DEPTH,
  parameter int INST_W  = 32,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`XLEN-1:0]  pc_addr,
  output logic              pc_write_flag,
  output logic [`XLEN-1:0]  pc_write_addr,
  output logic              imem_req,
  output logic [`XLEN-1:0]  imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_en,
  input  logic [`XLEN-1:0]  redirect_addr,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [`XLEN-1:0]  id_pc,
  output logic              fetch_fault
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = INST_W + XW;
  localparam logic [XW-1:0] STEP = XW'(PC_STEP);

  if_state_e       r_state;
  if_state_e       w_next;
  logic            r_epoch;
  logic            r_inflight;
  logic            r_tag;
  logic [XW-1:0]   r_req_pc;

  logic [CW-1:0]   w_cnt;
  logic [EW-1:0]   w_head;
  logic            w_nonempty;
  logic            w_redir;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic [OW-1:0]   w_occ;
  logic            w_try;
  logic            w_pc_ok;
  logic            w_issue;

  assign w_nonempty = (w_cnt != '0);
  // Redirects are ignored in the post-reset settle cycle.
  assign w_redir    = redirect_en && (r_state != IF_IDLE);
  assign w_valid    = w_nonempty && !redirect_en;
  assign w_pop      = w_valid && id_ready;
  assign w_occ      = OW'(w_cnt) + OW'(r_inflight) - OW'(w_pop);
  assign w_try      = (r_state == IF_RUN) && !redirect_en &&
                      (w_occ < OW'(QDEPTH));
  assign w_pc_ok    = pc_legal(pc_addr);
  assign w_issue    = w_try && w_pc_ok;
  assign w_push     = r_inflight && (r_tag == r_epoch);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IF_IDLE: w_next = IF_RUN;
      IF_RUN: begin
        if (redirect_en && !pc_legal(redirect_addr))
          w_next = IF_HALT;
        else if (w_try && !w_pc_ok)
          w_next = IF_HALT;
      end
      IF_HALT: begin
        if (redirect_en && pc_legal(redirect_addr))
          w_next = IF_RUN;
      end
      default: w_next = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IF_IDLE;
      r_epoch    <= 1'b0;
      r_inflight <= 1'b0;
      r_tag      <= 1'b0;
      r_req_pc   <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag    <= r_epoch;
        r_req_pc <= pc_addr;
      end
      if (w_redir) r_epoch <= ~r_epoch;
    end
  end

  if_fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (EW)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redir),
    .i_din   ({imem_rdata, r_req_pc}),
    .o_count (w_cnt),
    .o_head  (w_head)
  );

  assign pc_write_flag = (w_redir || w_issue) ?
                         `WRITE_ENABLE : !`WRITE_ENABLE;
  assign pc_write_addr = w_redir ? redirect_addr :
                         w_issue ? pc_addr + STEP : '0;
  assign imem_req      = w_issue;
  assign imem_addr     = w_issue ? pc_addr : '0;
  assign id_valid      = w_valid;
  assign id_inst       = w_nonempty ? w_head[EW-1:XW] : '0;
  assign id_pc         = w_nonempty ? w_head[XW-1:0] : '0;
  assign fetch_fault   = (r_state == IF_HALT);

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (r_state == IF_RUN) && !w_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_pop && (r_perf_fetch != '1))
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_stall && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: PC register and IT RAM models around the DUT,
// checked cycle by cycle against a queue-level reference of the fetch rules.
module tb_if_fetch_ctrl;

  localparam logic [31:0] BOOT  = `BOOT_IT_ADDR;
  localparam logic [31:0] LIMIT = `BOOT_IT_ADDR + `IT_RAM_DEPTH;
  localparam int          QD    = `FETCH_Q_DEPTH;

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_write_flag;
  logic [31:0] pc_write_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_fault;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .pc_write_flag (pc_write_flag),
    .pc_write_addr (pc_write_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .fetch_fault   (fetch_fault)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < LIMIT);
  endfunction

  // Environment: PC register and synchronous IT RAM.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_addr <= BOOT;
    else if (pc_write_flag) pc_addr <= pc_write_addr;
  end

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= memf(imem_addr);
  end

  int          checks;
  int          errors;
  logic [31:0] mq[$];
  bit          m_started;
  bit          m_halted;
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_pc;
  logic [31:0] m_pf;
  logic [31:0] m_ps;
  bit          last_valid;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_started = 0;
    m_halted  = 0;
    m_inf     = 0;
    m_inf_pc  = '0;
    m_pc      = BOOT;
    m_pf      = '0;
    m_ps      = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {imem_req, imem_addr}, '0);
    chk({tag, "_pcw"}, {pc_write_flag, pc_write_addr}, '0);
    chk({tag, "_dec"}, {id_valid, id_pc, id_inst}, '0);
    chk({tag, "_flt"}, fetch_fault, '0);
  endtask

  task automatic cycle(input bit rdy, input bit redir,
                       input logic [31:0] raddr);
    bit          rdeff, evalid, pop, want, iss;
    int          occ;
    logic [31:0] hpc;
    id_ready      = rdy;
    redirect_en   = redir;
    redirect_addr = raddr;
    @(negedge clk);
    rdeff  = redir && m_started;
    evalid = (mq.size() != 0) && !redir;
    pop    = evalid && rdy;
    occ    = mq.size() + int'(m_inf) - int'(pop);
    want   = m_started && !m_halted && !redir && (occ < QD);
    iss    = want && legal(m_pc);
    hpc    = (mq.size() != 0) ? mq[0] : 32'h0;
    last_valid = id_valid;
    chk("issue", {imem_req, imem_addr},
        {iss, iss ? m_pc : 32'h0});
    chk("pcwrite", {pc_write_flag, pc_write_addr},
        {rdeff || iss, rdeff ? raddr : iss ? m_pc + 32'd4 : 32'h0});
    chk("decode", {id_valid, id_pc, id_inst},
        {evalid, hpc, (mq.size() != 0) ? memf(hpc) : 32'h0});
    chk("fault", fetch_fault, m_halted);
`ifdef IF_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_pf);
    chk("perf_stall", perf_stall_cnt, m_ps);
`endif
    if (pop && m_pf != '1) m_pf++;
    if (m_started && !m_halted && !evalid && m_ps != '1) m_ps++;
    if (rdeff) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (m_inf) mq.push_back(m_inf_pc);
    end
    m_inf    = iss;
    m_inf_pc = m_pc;
    if (!m_started) m_started = 1;
    else if (m_halted) begin
      if (redir && legal(raddr)) m_halted = 0;
    end
    else if (redir) m_halted = !legal(raddr);
    else if (want && !legal(m_pc)) m_halted = 1;
    if (rdeff) m_pc = raddr;
    else if (iss) m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic release_and_start(input string tag);
    int first;
    rst   = 1'b1;
    first = -1;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (first < 0 && last_valid) first = k;
    end
    chk({tag, "_first_valid"}, first, 3);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    id_ready      = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
`ifdef IF_FETCH_PERF_EN
    chk("reset_perf", {perf_fetch_cnt, perf_stall_cnt}, '0);
`endif

    release_and_start("boot");
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Decode back-pressure, then drain.
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    chk("stall_full_req", imem_req, 1'b0);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with a request in flight.
    cycle(1'b1, 1'b1, BOOT + 32'h40);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Run off the end of the RAM, then recover.
    cycle(1'b1, 1'b1, LIMIT - 32'h10);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);
    chk("end_fault", {fetch_fault, imem_req}, {1'b1, 1'b0});
    cycle(1'b1, 1'b1, BOOT);
    chk("fault_clear", fetch_fault, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Misaligned redirect halts; legal one resumes.
    cycle(1'b1, 1'b1, BOOT + 32'h2);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, BOOT + 32'h80);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Reset mid-stream with the queue full.
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    id_ready    = 1'b0;
    redirect_en = 1'b0;
    rst         = 1'b0;
    #1;
    chk_zero("midreset");
`ifdef IF_FETCH_PERF_EN
    chk("midreset_perf", {perf_fetch_cnt, perf_stall_cnt}, '0);
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    release_and_start("restart");

    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      bit          rdy, rd;
      logic [31:0] tgt;
      rdy = ($urandom_range(3) != 0);
      rd  = ($urandom_range(19) == 0) || (m_pc > BOOT + 32'h300);
      tgt = BOOT + ($urandom_range(127) << 2);
      cycle(rdy, rd, tgt);
    end
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller sitting directly downstream of the PC register and feeding the decode stage.
- Reads the current PC and issues synchronous reads to the instruction RAM (IT RAM).
- Advances the PC by driving the PC register's write port with PC+4, or with a redirect target on branch/jump.
- Buffers returned instructions in a small queue and presents them to decode over a valid/ready handshake.

Parameters:
- QDEPTH, 2, instruction queue depth (power of 2, >=2).
- INST_W, 32, instruction width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- pc_addr  in  `XLEN  current PC from the PC register.
- pc_write_flag  out  1  PC register write strobe (`WRITE_ENABLE when asserted).
- pc_write_addr  out  `XLEN  next PC value to write.
- imem_req  out  1  IT RAM read request.
- imem_addr  out  `XLEN  IT RAM read address.
- imem_rdata  in  INST_W  IT RAM read data, valid exactly 1 cycle after imem_req.
- redirect_en  in  1  branch/jump redirect from execute.
- redirect_addr  in  `XLEN  redirect target.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts the instruction.
- id_inst  out  INST_W  instruction to decode.
- id_pc  out  `XLEN  PC of id_inst.
- fetch_fault  out  1  fetch halted on an illegal PC.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; queue count = 0; no request in flight; epoch = 0.
  - Outputs imem_req, pc_write_flag, id_valid and fetch_fault = 0; all address and data outputs = 0.
- States:
  - IDLE -> RUN unconditionally on the first clock after reset release. This one-cycle gap lets the PC register settle at `BOOT_IT_ADDR.
  - RUN -> HALT when an issue would occur with an illegal pc_addr: pc_addr[1:0] != 0, or pc_addr >= `BOOT_IT_ADDR + `IT_RAM_DEPTH.
  - HALT: fetch_fault = 1, no issue. HALT -> RUN only on redirect_en with a legal redirect_addr.
- Issue condition, RUN only: (count + inflight - pop) < QDEPTH and redirect_en = 0, where pop = id_valid & id_ready.
- On issue:
  - imem_req = 1 and imem_addr = pc_addr.
  - pc_write_flag = 1 and pc_write_addr = pc_addr + PC_STEP, modulo 2^`XLEN; wrap is caught by the range check.
  - Record inflight = 1, tagging the request with the current epoch and its PC.
- Response:
  - On the cycle after an issue, if the request tag equals the current epoch, push {imem_rdata, pc} into the queue. Otherwise discard it.
  - Push and pop in the same cycle are legal; count is unchanged.
  - The issue rule guarantees no overflow. A push when full is an assertion failure.
- Sustained throughput is 1 instruction/cycle when id_ready is held high. First-fetch latency: reset release to first id_valid = 3 cycles (IDLE, issue, push).
- Output to decode:
  - id_valid = (count != 0) & ~redirect_en.
  - id_inst and id_pc come from the queue head and stay stable while id_valid = 1 and id_ready = 0.
- Redirect (priority over everything else):
  - In the same cycle: pc_write_flag = 1, pc_write_addr = redirect_addr, imem_req = 0, no handshake completes.
  - Next edge: queue flushed, epoch toggled, so any in-flight response is dropped.
  - An illegal redirect_addr enters HALT; the PC register ignores the write anyway.
- Reset mid-operation: all state cleared immediately; any pending imem_rdata is ignored.
- Any cycle that neither issues nor redirects drives pc_write_flag = 0.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- When defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments per completed decode handshake.
  - perf_stall_cnt increments per cycle with id_valid = 0 in RUN state.
  - Both counters saturate at 0xFFFF_FFFF and clear on reset only.
- When undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

Decomposition:
- Shared config header: `XLEN, `BOOT_IT_ADDR, `IT_RAM_DEPTH and `WRITE_ENABLE, plus the new constants `FETCH_Q_DEPTH and state encodings IF_IDLE = 2'd0, IF_RUN = 2'd1, IF_HALT = 2'd2.
- One sub-module, if_fetch_queue: a synchronous FIFO of {INST_W + `XLEN} bits with push, pop, flush, count, and head outputs. The controller keeps the FSM, issue logic and epoch.

Test Plan:
- Reset release with id_ready = 1 -> imem_addr sequence `BOOT_IT_ADDR, +4, +8, ...; first id_valid 3 cycles after release; then one instruction per cycle with id_pc matching.
- Hold id_ready = 0 for 5 cycles -> at most QDEPTH = 2 entries buffered, imem_req = 0 once full, id_inst/id_pc stable; on release, in-order delivery with no loss.
- redirect_en with redirect_addr = `BOOT_IT_ADDR + 0x40 while one request is in flight -> stale response dropped; next id_pc = `BOOT_IT_ADDR + 0x40.
- Sequential fetch reaching `BOOT_IT_ADDR + `IT_RAM_DEPTH -> fetch_fault = 1, imem_req stays 0; redirect to `BOOT_IT_ADDR -> fault clears and fetch resumes.
- Assert rst low mid-stream with queue full -> id_valid = 0 and count = 0 immediately; after release, fetch restarts at `BOOT_IT_ADDR.
- With IF_FETCH_PERF_EN defined: 10 handshakes plus 4 stall cycles -> perf_fetch_cnt = 10, perf_stall_cnt = 4.
